// File: rtl/dual_core_mem_arbiter.sv
// Arbitrates one RAM port between two cores' icache and dcache requesters,
// data ahead of instruction, round-robin across cores, with per-core LL/SC links.
module dual_core_mem_arbiter #(
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned LINK_LSB = 2,
  parameter logic        RR_RESET = 1'b0
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [1:0]            iREN,
  input  logic [2*WORD_W-1:0]   iaddr,
  input  logic [1:0]            dREN,
  input  logic [1:0]            dWEN,
  input  logic [1:0]            datomic,
  input  logic [2*WORD_W-1:0]   daddr,
  input  logic [2*WORD_W-1:0]   dstore,
  output logic [1:0]            iwait,
  output logic [1:0]            dwait,
  output logic [2*WORD_W-1:0]   iload,
  output logic [2*WORD_W-1:0]   dload,
  output logic                  ramREN,
  output logic                  ramWEN,
  output logic [WORD_W-1:0]     ramaddr,
  output logic [WORD_W-1:0]     ramstore,
  input  logic [WORD_W-1:0]     ramload,
  input  logic [1:0]            ramstate
);

  localparam int unsigned TAG_W     = WORD_W - LINK_LSB;
  localparam logic [1:0]  RS_ACCESS = 2'd2;

  typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, SCFAIL = 2'd2} state_e;

  state_e            state_q, state_d;
  logic              core_q, core_d;
  logic              data_q, data_d;
  logic              wr_q, wr_d;
  logic              atom_q, atom_d;
  logic              rr_q, rr_d;
  logic [1:0]        lvalid_q, lvalid_d;
  logic [TAG_W-1:0]  ltag_q [2];
  logic [TAG_W-1:0]  ltag_d [2];

  logic [WORD_W-1:0] ia [2];
  logic [WORD_W-1:0] da [2];
  logic [WORD_W-1:0] ds [2];
  logic [1:0]        dreq, cand;
  logic              win, live, done;
  logic [WORD_W-1:0] load_v;

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      ia[n] = iaddr[WORD_W*n +: WORD_W];
      da[n] = daddr[WORD_W*n +: WORD_W];
      ds[n] = dstore[WORD_W*n +: WORD_W];
    end
  end

  // Class priority first, then round-robin only on a true tie.
  assign dreq = dREN | dWEN;
  assign cand = (|dreq) ? dreq : iREN;
  assign win  = (&cand) ? rr_q : cand[1];
  assign live = (state_q == SERVE) &&
                (data_q ? (wr_q ? dWEN[core_q] : dREN[core_q]) : iREN[core_q]);
  assign done = live && (ramstate == RS_ACCESS);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      core_q   <= 1'b0;
      data_q   <= 1'b0;
      wr_q     <= 1'b0;
      atom_q   <= 1'b0;
      rr_q     <= RR_RESET;
      lvalid_q <= 2'b00;
      ltag_q   <= '{default: '0};
    end else begin
      state_q  <= state_d;
      core_q   <= core_d;
      data_q   <= data_d;
      wr_q     <= wr_d;
      atom_q   <= atom_d;
      rr_q     <= rr_d;
      lvalid_q <= lvalid_d;
      ltag_q   <= ltag_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    core_d   = core_q;
    data_d   = data_q;
    wr_d     = wr_q;
    atom_d   = atom_q;
    rr_d     = rr_q;
    lvalid_d = lvalid_q;
    ltag_d   = ltag_q;
    unique case (state_q)
      IDLE: begin
        if (|cand) begin
          core_d = win;
          data_d = |dreq;
          wr_d   = (|dreq) & dWEN[win];
          atom_d = (|dreq) & datomic[win];
          // An SC whose link is gone fails here without touching RAM.
          if ((|dreq) && dWEN[win] && datomic[win] &&
              !(lvalid_q[win] && (ltag_q[win] == da[win][WORD_W-1:LINK_LSB])))
            state_d = SCFAIL;
          else
            state_d = SERVE;
        end
      end
      SERVE: begin
        if (!live) begin
          state_d = IDLE;
        end else if (done) begin
          state_d = IDLE;
          rr_d    = ~core_q;
          if (data_q && wr_q) begin
            for (int n = 0; n < 2; n++)
              if (lvalid_q[n] && (ltag_q[n] == da[core_q][WORD_W-1:LINK_LSB]))
                lvalid_d[n] = 1'b0;
          end else if (data_q && atom_q) begin
            lvalid_d[core_q] = 1'b1;
            ltag_d[core_q]   = da[core_q][WORD_W-1:LINK_LSB];
          end
        end
      end
      SCFAIL: begin
        state_d          = IDLE;
        rr_d             = ~core_q;
        lvalid_d[core_q] = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Only the granted requester ever sees its strobes or its completion.
  always_comb begin
    iwait    = 2'b11;
    dwait    = 2'b11;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    load_v   = (wr_q && atom_q) ? WORD_W'(1) : ramload;
    if (live) begin
      ramREN   = !(data_q && wr_q);
      ramWEN   = data_q && wr_q;
      ramaddr  = data_q ? da[core_q] : ia[core_q];
      ramstore = (data_q && wr_q) ? ds[core_q] : '0;
    end
    if (done) begin
      if (data_q) begin
        dwait[core_q] = 1'b0;
        if (core_q) dload[2*WORD_W-1:WORD_W] = load_v;
        else        dload[WORD_W-1:0]        = load_v;
      end else begin
        iwait[core_q] = 1'b0;
        if (core_q) iload[2*WORD_W-1:WORD_W] = load_v;
        else        iload[WORD_W-1:0]        = load_v;
      end
    end
    if (state_q == SCFAIL) dwait[core_q] = 1'b0;
  end

endmodule
